// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, per-channel
// double-buffered duty (shadow written any time, active latched at frame start).
module servo_pwm_multi #(
  parameter int CLK_HZ     = 25000000,
  parameter int FRAME_HZ   = 50,
  parameter int CHANNELS   = 4,
  parameter int DUTY_W     = 8,
  parameter int MIN_CLKS   = 25000,
  parameter int STEP_CLKS  = 98,
  parameter int DUTY_RESET = 128
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic [CHANNELS-1:0]                           ch_en,
  input  logic                                          wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
  input  logic [DUTY_W-1:0]                             wr_duty,
  output logic [CHANNELS-1:0]                           pwm,
  output logic                                          frame_start
);

  localparam int FRAME_CLKS = CLK_HZ / FRAME_HZ;
  localparam int CW         = $clog2(FRAME_CLKS);
  localparam int WCH        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MAX_W      = MIN_CLKS + ((2 ** DUTY_W) - 1) * STEP_CLKS;

  // The longest pulse must end before the frame wraps, and the reset duty must fit.
  if (MAX_W >= FRAME_CLKS) begin : g_bad_width
    $error("servo_pwm_multi: maximum pulse width does not fit in one frame");
  end
  if (DUTY_RESET >= (2 ** DUTY_W)) begin : g_bad_reset_duty
    $error("servo_pwm_multi: DUTY_RESET does not fit in DUTY_W bits");
  end

  logic [CW-1:0]       cnt_reg;
  logic                cnt_zero;
  logic [CHANNELS-1:0] pwm_next;

  assign cnt_zero = (cnt_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DUTY_W-1:0] shadow_reg;
      logic [DUTY_W-1:0] duty_reg;
      logic              act_en_reg;
      logic [31:0]       width;

      // wr_ch values with no matching channel simply match no block.
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg <= DUTY_W'(DUTY_RESET);
          duty_reg   <= DUTY_W'(DUTY_RESET);
          act_en_reg <= 1'b0;
        end else begin
          if (wr_en && (wr_ch == WCH'(gi))) begin
            shadow_reg <= wr_duty;
          end
          if (en && cnt_zero) begin
            duty_reg   <= shadow_reg;
            act_en_reg <= ch_en[gi];
          end
        end
      end

      assign width = 32'(MIN_CLKS) + 32'(duty_reg) * 32'(STEP_CLKS);

      // In the cnt=0 cycle the active copy is being loaded, so the first pulse
      // cycle is decided from ch_en directly (every width is at least one clock).
      assign pwm_next[gi] = cnt_zero ? ch_en[gi]
                                     : (act_en_reg && (32'(cnt_reg) < width));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      frame_start <= 1'b0;
      pwm         <= '0;
    end else if (!en) begin
      cnt_reg     <= '0;
      frame_start <= 1'b0;
      pwm         <= '0;
    end else begin
      cnt_reg     <= (cnt_reg == CW'(FRAME_CLKS - 1)) ? '0 : cnt_reg + 1'b1;
      frame_start <= cnt_zero;
      pwm         <= pwm_next;
    end
  end

endmodule
